vec_dot_sequencer: RTL
======================

VEC_DOT_SEQUENCER -- requirements
Module: vec_dot_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request one dot-product pass; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: synchronous cancel of an active pass.
REQ-005 SHALL have port len, input, 9 bits: element count, latched on accepted start.
REQ-006 SHALL have ports base_a and base_b, input, 9 bits each: vector base addresses, latched on accepted start.
REQ-007 SHALL have ports addr_a and addr_b, output, 9 bits each: vector-memory read addresses, registered.
REQ-008 SHALL have port rd_en, output, 1 bit: memory read strobe.
REQ-009 SHALL have ports e_mul and e_acc, output, 1 bit each: datapath multiply and accumulate enables.
REQ-010 SHALL have port clr_acc, output, 1 bit: accumulator clear.
REQ-011 SHALL have port store, output, 1 bit: write accumulator result.
REQ-012 SHALL have ports busy, done and err, output, 1 bit each: pass active, pass-complete pulse, and rejected-start pulse.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, ISSUE, DRAIN, STORE, DONE.
REQ-014 IDLE with start=1 and len!=0 SHALL latch len, base_a and base_b, and go to CLEAR.
REQ-015 IDLE with start=1 and len==0 SHALL pulse err for 1 cycle and remain IDLE.
REQ-016 CLEAR SHALL assert clr_acc for exactly 1 cycle, then go to ISSUE with idx=0.
REQ-017 ISSUE SHALL assert rd_en with addr_a=base_a+idx and addr_b=base_b+idx (mod 512) for len consecutive cycles, incrementing idx each cycle, then go to DRAIN.
REQ-018 e_mul SHALL equal rd_en delayed 1 cycle, and e_acc SHALL equal rd_en delayed 2 cycles (1-cycle memory read latency, 1-cycle multiply).
REQ-019 DRAIN SHALL last exactly 2 cycles, then go to STORE.
REQ-020 STORE SHALL assert store for 1 cycle, then go to DONE.
REQ-021 DONE SHALL assert done for 1 cycle, then go to IDLE.
REQ-022 Timing, with start sampled at edge 0: clr_acc in cycle 1; rd_en in cycles 2..len+1; e_acc in cycles 4..len+3; store in cycle len+4; done in cycle len+5.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear the delay pipeline, and suppress store and done.
REQ-026 abort in IDLE SHALL have no effect.
REQ-027 If abort and start are both high in IDLE, start SHALL be accepted.
REQ-028 Address arithmetic SHALL be 9-bit modular, so 511+1 wraps to 0 with no error.
REQ-029 len=511 SHALL complete normally.
REQ-030 When not in ISSUE, addr_a and addr_b SHALL hold their last values.

Reset
REQ-031 rst=1 SHALL, on the next edge, force IDLE and set idx=0 and latched len/bases=0.
REQ-032 rst=1 SHALL set addr_a=addr_b=0 and drive rd_en, e_mul, e_acc, clr_acc, store, busy, done and err to 0.
REQ-033 rst SHALL take priority over abort and start, including mid-pass, with no store or done emitted.

Structure
REQ-034 A shared package SHALL hold ADDR_W=9, DATA_W=24, DRAIN_CYC=2 and the FSM state enumeration.
REQ-035 A sub-module vec_seq_pipe_delay SHALL implement the 2-stage rd_en-to-e_mul/e_acc shift register, with synchronous clear driven by rst or abort.

Verification
REQ-036 len=3, base_a=0, base_b=256, start at edge 0 SHALL give addr pairs (0,256), (1,257), (2,258) in cycles 2-4, e_acc in cycles 4-6, store in cycle 7, done in cycle 8.
REQ-037 start with len=0 SHALL give a 1-cycle err pulse, busy staying 0, and no rd_en.
REQ-038 base_a=510, len=4 SHALL give addr_a sequence 510, 511, 0, 1.
REQ-039 abort in the 2nd ISSUE cycle of a len=5 pass SHALL give IDLE next cycle, e_mul and e_acc 0 one cycle later, and no store or done.
REQ-040 start re-pulsed during ISSUE SHALL be ignored, with exactly one done per accepted start.
REQ-041 rst asserted during DRAIN SHALL zero all outputs on the next edge, and a subsequent len=1 pass SHALL give done in cycle 6.

Source files
------------

// File: rtl/vec_dot_sequencer_pkg.sv
// Shared constants and FSM state type for the vector dot-product sequencer.
package vec_dot_sequencer_pkg;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 24;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_DRAIN,
    ST_STORE,
    ST_DONE
  } state_t;

  // Modular address increment; wraps at 2**ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/vec_seq_pipe_delay.sv
// Two-stage shift register aligning the read strobe with the multiply and
// accumulate stages of the datapath (one cycle memory latency, one cycle
// multiply).
module vec_seq_pipe_delay (
  input  logic clk,
  input  logic clr,
  input  logic in_bit,
  output logic d1,
  output logic d2
);

  // Shift rd_en through two stages; clr flushes anything in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= in_bit;
      d2 <= d1;
    end
  end

endmodule

// File: rtl/vec_dot_sequencer.sv
// Control sequencer for one dot-product pass over two vectors held in a
// shared vector memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; len==0 start is rejected with err
// ST_CLEAR | one-cycle accumulator clear
// ST_ISSUE | one memory read per cycle, len cycles
// ST_DRAIN | let the last products reach the accumulator
// ST_STORE | write the accumulated result
// ST_DONE  | one-cycle completion pulse
module vec_dot_sequencer
  import vec_dot_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              rd_en,
  output logic              e_mul,
  output logic              e_acc,
  output logic              clr_acc,
  output logic              store,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [1:0]        drain_cnt;
  logic              err_q;
  logic              accept;
  logic              issue_last;
  logic              abort_act;
  logic              pipe_clr;

  assign accept     = (state == ST_IDLE) && start && (len != '0);
  assign issue_last = (idx == (len_q - {{(ADDR_W-1){1'b0}}, 1'b1}));
  // Abort only means something while a pass is running.
  assign abort_act  = abort && (state != ST_IDLE);
  assign pipe_clr   = rst || abort_act;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    clr_acc   = 1'b0;
    rd_en     = 1'b0;
    store     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_acc   = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        if (issue_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == 2'd0) state_nxt = ST_STORE;
      end
      ST_STORE: begin
        // A cancel arriving in this very cycle must not commit a result.
        store     = !abort && !rst;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = !abort && !rst;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort_act) state_nxt = ST_IDLE;
  end

  // Latch pass parameters on an accepted start; flag rejected starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == ST_IDLE) && start && (len == '0);
      if (accept) begin
        len_q    <= len;
        base_a_q <= base_a;
        base_b_q <= base_b;
      end
    end
  end

  assign err = err_q;

  // Element index and read addresses; held outside ISSUE and on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      addr_a <= '0;
      addr_b <= '0;
    end else if (state == ST_CLEAR && !abort) begin
      idx    <= '0;
      addr_a <= base_a_q;
      addr_b <= base_b_q;
    end else if (state == ST_ISSUE && !abort && !issue_last) begin
      idx    <= idx + {{(ADDR_W-1){1'b0}}, 1'b1};
      addr_a <= addr_inc(addr_a);
      addr_b <= addr_inc(addr_b);
    end
  end

  // Drain down-counter; terminal count 0 releases the FSM into STORE.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      drain_cnt <= 2'(DRAIN_CYC - 1);
    end else if (state == ST_DRAIN && drain_cnt != 2'd0) begin
      drain_cnt <= drain_cnt - 2'd1;
    end
  end

  vec_seq_pipe_delay u_pipe (
    .clk    (clk),
    .clr    (pipe_clr),
    .in_bit (rd_en),
    .d1     (e_mul),
    .d2     (e_acc)
  );

endmodule
